// File: rtl/core_fwd_pkg.sv
// Shared types and widths for the operand-forwarding / hold logic.
package core_fwd_pkg;

    localparam int unsigned FWD_DATA_W    = 32;
    localparam int unsigned SRC_NUM_DEF   = 3;
    localparam int unsigned ISSUE_W_DEF   = 2;
    localparam int unsigned RPORT_NUM_DEF = 2;
    localparam int unsigned TAG_W_DEF     = 4;
    localparam int unsigned WAY_BITS      = $clog2(ISSUE_W_DEF);
    localparam int unsigned FWD_ID_W      = TAG_W_DEF - WAY_BITS;

    // One result-bus slot: producer id excludes the way bits of the tag.
    typedef struct packed {
        logic                  valid;
        logic [FWD_ID_W-1:0]   id;
        logic [FWD_DATA_W-1:0] data;
    } fwd_data_t;

endpackage

// File: rtl/core_fwd_hold_port.sv
// One read port: tag match against all sources, priority select and hold register.
// CORE_FWD_CAPT_CNT_EN exposes the per-cycle capture pulse for the event counter.
module core_fwd_hold_port
    import core_fwd_pkg::*;
#(
    parameter int unsigned SRC_NUM = SRC_NUM_DEF,
    parameter int unsigned ISSUE_W = ISSUE_W_DEF,
    parameter int unsigned TAG_W   = TAG_W_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  fwd_data_t [SRC_NUM-1:0][ISSUE_W-1:0] fwd_bus_i,
    input  logic                                 stall_i,
    input  logic                                 flush_i,
    input  logic [TAG_W-1:0]                     r_id_i,
    input  logic                                 r_ready_i,
    input  logic [FWD_DATA_W-1:0]                r_d_i,
    output logic                                 r_ready_o,
    output logic [FWD_DATA_W-1:0]                r_d_o
`ifdef CORE_FWD_CAPT_CNT_EN
    ,
    output logic                                 capt_c
`endif
);

    localparam int unsigned PORT_WAY_BITS = $clog2(ISSUE_W);

    logic [PORT_WAY_BITS-1:0] w_way;
    logic                     w_hit;
    logic [FWD_DATA_W-1:0]    w_hit_d;
    logic                     w_capt;
    logic                     r_hold_v;
    logic [FWD_DATA_W-1:0]    r_hold_d;

    assign w_way = r_id_i[PORT_WAY_BITS-1:0];

    // Match all sources on the selected way; descending scan lets source 0 win.
    always_comb begin
        w_hit   = 1'b0;
        w_hit_d = '0;
        for (int s = SRC_NUM - 1; s >= 0; s--) begin
            if (fwd_bus_i[s][w_way].valid &&
                fwd_bus_i[s][w_way].id == r_id_i[TAG_W-1:PORT_WAY_BITS]) begin
                w_hit   = 1'b1;
                w_hit_d = fwd_bus_i[s][w_way].data;
            end
        end
    end

    // Operand select: register-file value, then held capture, then live forward.
    always_comb begin
        r_ready_o = 1'b0;
        r_d_o     = '0;
        if (r_ready_i) begin
            r_ready_o = 1'b1;
            r_d_o     = r_d_i;
        end else if (r_hold_v) begin
            r_ready_o = 1'b1;
            r_d_o     = r_hold_d;
        end else if (w_hit) begin
            r_ready_o = 1'b1;
            r_d_o     = w_hit_d;
        end
    end

    assign w_capt = stall_i && !flush_i && !r_ready_i && !r_hold_v && w_hit;

`ifdef CORE_FWD_CAPT_CNT_EN
    assign capt_c = w_capt;
`endif

    // Hold register: release (advance or flush) wins over a new capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_v <= 1'b0;
            r_hold_d <= '0;
        end else if (!stall_i || flush_i) begin
            r_hold_v <= 1'b0;
        end else if (w_capt) begin
            r_hold_v <= 1'b1;
            r_hold_d <= w_hit_d;
        end
    end

endmodule

// File: rtl/core_fwd_hold_unit.sv
// Operand-forwarding unit: RPORT_NUM independent hold ports plus stage-level ready flag.
// CORE_FWD_CAPT_CNT_EN enables the 32-bit capture event counter on capt_cnt_o.
module core_fwd_hold_unit
    import core_fwd_pkg::*;
#(
    parameter int unsigned SRC_NUM   = SRC_NUM_DEF,
    parameter int unsigned ISSUE_W   = ISSUE_W_DEF,
    parameter int unsigned RPORT_NUM = RPORT_NUM_DEF,
    parameter int unsigned TAG_W     = TAG_W_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  fwd_data_t [SRC_NUM-1:0][ISSUE_W-1:0]   fwd_bus_i,
    input  logic                                   stall_i,
    input  logic                                   flush_i,
    input  logic [RPORT_NUM-1:0][TAG_W-1:0]        r_id_i,
    input  logic [RPORT_NUM-1:0]                   r_ready_i,
    input  logic [RPORT_NUM-1:0][FWD_DATA_W-1:0]   r_d_i,
    output logic [RPORT_NUM-1:0][TAG_W-1:0]        r_id_o,
    output logic [RPORT_NUM-1:0]                   r_ready_o,
    output logic [RPORT_NUM-1:0][FWD_DATA_W-1:0]   r_d_o,
    output logic                                   all_ready_o,
    output logic [31:0]                            capt_cnt_o
);

`ifdef CORE_FWD_CAPT_CNT_EN
    logic [RPORT_NUM-1:0] w_capt;
    logic [31:0]          w_capt_sum;
    logic [31:0]          r_capt_cnt;
`endif

    assign r_id_o = r_id_i;

    // One hold port per read operand.
    for (genvar p = 0; p < RPORT_NUM; p++) begin : g_port
        core_fwd_hold_port #(
            .SRC_NUM (SRC_NUM),
            .ISSUE_W (ISSUE_W),
            .TAG_W   (TAG_W)
        ) u_port (
            .clk       (clk),
            .rst_n     (rst_n),
            .fwd_bus_i (fwd_bus_i),
            .stall_i   (stall_i),
            .flush_i   (flush_i),
            .r_id_i    (r_id_i[p]),
            .r_ready_i (r_ready_i[p]),
            .r_d_i     (r_d_i[p]),
            .r_ready_o (r_ready_o[p]),
            .r_d_o     (r_d_o[p])
`ifdef CORE_FWD_CAPT_CNT_EN
            ,
            .capt_c    (w_capt[p])
`endif
        );
    end

    assign all_ready_o = &r_ready_o;

`ifdef CORE_FWD_CAPT_CNT_EN
    // Number of ports capturing this cycle.
    always_comb begin
        w_capt_sum = '0;
        for (int p = 0; p < RPORT_NUM; p++) begin
            w_capt_sum = w_capt_sum + 32'(w_capt[p]);
        end
    end

    // Free-running capture event counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_capt_cnt <= '0;
        end else begin
            r_capt_cnt <= r_capt_cnt + w_capt_sum;
        end
    end

    assign capt_cnt_o = r_capt_cnt;
`else
    assign capt_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_core_fwd_hold_unit.sv
// Directed self-checking bench for core_fwd_hold_unit (default parameters).
module tb_core_fwd_hold_unit;
    import core_fwd_pkg::*;

    logic                    clk;
    logic                    rst_n;
    fwd_data_t [2:0][1:0]    fwd_bus;
    logic                    stall;
    logic                    flush;
    logic [1:0][3:0]         r_id;
    logic [1:0]              r_ready;
    logic [1:0][31:0]        r_d;
    logic [1:0][3:0]         r_id_o;
    logic [1:0]              r_ready_o;
    logic [1:0][31:0]        r_d_o;
    logic                    all_ready;
    logic [31:0]             capt_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_cnt = 32'h0;

    core_fwd_hold_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fwd_bus_i   (fwd_bus),
        .stall_i     (stall),
        .flush_i     (flush),
        .r_id_i      (r_id),
        .r_ready_i   (r_ready),
        .r_d_i       (r_d),
        .r_id_o      (r_id_o),
        .r_ready_o   (r_ready_o),
        .r_d_o       (r_d_o),
        .all_ready_o (all_ready),
        .capt_cnt_o  (capt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a capture only in the counter-enabled build.
    task automatic add_capt(input int n);
`ifdef CORE_FWD_CAPT_CNT_EN
        exp_cnt = exp_cnt + 32'(n);
`else
        if (n < 0) exp_cnt = 32'h0;
`endif
    endtask

    task automatic clr_bus();
        for (int s = 0; s < 3; s++)
            for (int w = 0; w < 2; w++)
                fwd_bus[s][w] = '0;
    endtask

    task automatic set_fwd(input int s, input int w, input logic [2:0] id, input logic [31:0] d);
        fwd_bus[s][w].valid = 1'b1;
        fwd_bus[s][w].id    = id;
        fwd_bus[s][w].data  = d;
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        r_id = '0; r_ready = '0; r_d = '0;
        clr_bus();
        #2;
        n_vec++;
        if (r_ready_o !== 2'b00 || r_d_o !== 64'h0 || all_ready !== 1'b0 || capt_cnt !== 32'h0) begin
            n_err++;
            $display("FAIL reset: ready=%b d=%h all=%b cnt=%0d, want 00/0/0/0", r_ready_o, r_d_o, all_ready, capt_cnt);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_no_stall();
        r_id[0] = 4'b0101; r_id[1] = 4'b1111;
        set_fwd(1, 1, 3'b010, 32'hDEAD_BEEF);
        #1;
        n_vec++;
        if (r_ready_o[0] !== 1'b1 || r_d_o[0] !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL no_stall_fwd: ready=%b d=%h, want 1 deadbeef", r_ready_o[0], r_d_o[0]);
        end
        n_vec++;
        if (r_ready_o[1] !== 1'b0 || all_ready !== 1'b0 || r_id_o !== r_id) begin
            n_err++;
            $display("FAIL no_stall_port1: ready1=%b all=%b id_o=%h, want 0 0 %h", r_ready_o[1], all_ready, r_id_o, r_id);
        end
        step();
        clr_bus();
        #1;
        n_vec++;
        if (r_ready_o[0] !== 1'b0 || r_d_o[0] !== 32'h0 || capt_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL no_stall_nocapt: ready=%b d=%h cnt=%0d, want 0 0 %0d", r_ready_o[0], r_d_o[0], capt_cnt, exp_cnt);
        end
    endtask

    task automatic test_stall_capture();
        stall = 1'b1;
        r_id[0] = 4'b0101;
        set_fwd(2, 1, 3'b010, 32'h1234);
        step();
        add_capt(1);
        clr_bus();
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (r_ready_o[0] !== 1'b1 || r_d_o[0] !== 32'h1234) begin
                n_err++;
                $display("FAIL stall_hold c%0d: ready=%b d=%h, want 1 1234", c, r_ready_o[0], r_d_o[0]);
            end
            step();
        end
        stall = 1'b0;
        #1;
        n_vec++;
        if (r_ready_o[0] !== 1'b1 || r_d_o[0] !== 32'h1234 || capt_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL stall_release_cycle: ready=%b d=%h cnt=%0d, want 1 1234 %0d", r_ready_o[0], r_d_o[0], capt_cnt, exp_cnt);
        end
        step();
        n_vec++;
        if (r_ready_o[0] !== 1'b0 || r_d_o[0] !== 32'h0) begin
            n_err++;
            $display("FAIL stall_after_release: ready=%b d=%h, want 0 0", r_ready_o[0], r_d_o[0]);
        end
    endtask

    task automatic test_multi_hit();
        r_id[0] = 4'b0110;
        set_fwd(0, 0, 3'b011, 32'h1);
        set_fwd(2, 0, 3'b011, 32'h2);
        #1;
        n_vec++;
        if (r_ready_o[0] !== 1'b1 || r_d_o[0] !== 32'h1) begin
            n_err++;
            $display("FAIL multi_hit_prio: ready=%b d=%h, want 1 1", r_ready_o[0], r_d_o[0]);
        end
        step();
        clr_bus();
        stall = 1'b1;
        set_fwd(1, 0, 3'b011, 32'h7);
        step();
        add_capt(1);
        clr_bus();
        set_fwd(0, 0, 3'b011, 32'h9);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (r_ready_o[0] !== 1'b1 || r_d_o[0] !== 32'h7) begin
                n_err++;
                $display("FAIL hold_sticky c%0d: ready=%b d=%h, want 1 7", c, r_ready_o[0], r_d_o[0]);
            end
            step();
        end
        n_vec++;
        if (capt_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL hold_sticky_cnt: cnt=%0d, want %0d", capt_cnt, exp_cnt);
        end
        clr_bus();
        stall = 1'b0;
        step();
    endtask

    task automatic test_ready_bypass();
        stall = 1'b1;
        r_id[0] = 4'b0101;
        r_ready[0] = 1'b1; r_d[0] = 32'hA5A5;
        set_fwd(0, 1, 3'b010, 32'h5555);
        #1;
        n_vec++;
        if (r_ready_o[0] !== 1'b1 || r_d_o[0] !== 32'hA5A5) begin
            n_err++;
            $display("FAIL bypass_prio: ready=%b d=%h, want 1 a5a5", r_ready_o[0], r_d_o[0]);
        end
        step();
        r_ready[0] = 1'b0; r_d[0] = '0;
        clr_bus();
        #1;
        n_vec++;
        if (r_ready_o[0] !== 1'b0 || r_d_o[0] !== 32'h0 || capt_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL bypass_nocapt: ready=%b d=%h cnt=%0d, want 0 0 %0d", r_ready_o[0], r_d_o[0], capt_cnt, exp_cnt);
        end
        stall = 1'b0;
        step();
    endtask

    task automatic test_flush_reset();
        stall = 1'b1;
        r_id[0] = 4'b0101;
        set_fwd(1, 1, 3'b010, 32'hCAFE);
        step();
        add_capt(1);
        clr_bus();
        flush = 1'b1;
        #1;
        n_vec++;
        if (r_ready_o[0] !== 1'b1 || r_d_o[0] !== 32'hCAFE) begin
            n_err++;
            $display("FAIL flush_same_cycle: ready=%b d=%h, want 1 cafe", r_ready_o[0], r_d_o[0]);
        end
        step();
        flush = 1'b0;
        #1;
        n_vec++;
        if (r_ready_o[0] !== 1'b0 || r_d_o[0] !== 32'h0 || capt_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL flush_cleared: ready=%b d=%h cnt=%0d, want 0 0 %0d", r_ready_o[0], r_d_o[0], capt_cnt, exp_cnt);
        end
        set_fwd(2, 1, 3'b010, 32'hBEEF);
        step();
        add_capt(1);
        clr_bus();
        #1;
        n_vec++;
        if (r_ready_o[0] !== 1'b1 || r_d_o[0] !== 32'hBEEF || capt_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL recapture: ready=%b d=%h cnt=%0d, want 1 beef %0d", r_ready_o[0], r_d_o[0], capt_cnt, exp_cnt);
        end
        #1;
        rst_n = 1'b0;
        exp_cnt = 32'h0;
        #1;
        n_vec++;
        if (r_ready_o[0] !== 1'b0 || r_d_o[0] !== 32'h0 || capt_cnt !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: ready=%b d=%h cnt=%0d, want 0 0 0", r_ready_o[0], r_d_o[0], capt_cnt);
        end
        step();
        rst_n = 1'b1;
        stall = 1'b0;
        step();
    endtask

    task automatic test_dual_capture();
        stall = 1'b1;
        r_id[0] = 4'b1001; r_id[1] = 4'b1001;
        set_fwd(1, 1, 3'b100, 32'h0BAD_F00D);
        #1;
        n_vec++;
        if (r_d_o[0] !== 32'h0BAD_F00D || r_d_o[1] !== 32'h0BAD_F00D || all_ready !== 1'b1) begin
            n_err++;
            $display("FAIL dual_fwd: d0=%h d1=%h all=%b, want 0badf00d x2 1", r_d_o[0], r_d_o[1], all_ready);
        end
        step();
        add_capt(2);
        clr_bus();
        #1;
        n_vec++;
        if (r_d_o[0] !== 32'h0BAD_F00D || r_d_o[1] !== 32'h0BAD_F00D || all_ready !== 1'b1 || capt_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL dual_capt: d0=%h d1=%h all=%b cnt=%0d, want 0badf00d x2 1 %0d", r_d_o[0], r_d_o[1], all_ready, capt_cnt, exp_cnt);
        end
        stall = 1'b0;
        step();
        stall = 1'b1;
        r_id[0] = 4'b1111;
        set_fwd(0, 0, 3'b001, 32'h42);
        r_id[1] = 4'b0010;
        step();
        add_capt(1);
        clr_bus();
        #1;
        n_vec++;
        if (r_ready_o !== 2'b10 || r_d_o[1] !== 32'h42 || all_ready !== 1'b0 || capt_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL single_capt: ready=%b d1=%h all=%b cnt=%0d, want 10 42 0 %0d", r_ready_o, r_d_o[1], all_ready, capt_cnt, exp_cnt);
        end
        stall = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_no_stall();
        test_stall_capture();
        test_multi_hit();
        test_ready_bypass();
        test_flush_reset();
        test_dual_capture();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
